aes_input_loader: RTL and testbench
===================================

// Module: aes_input_loader
// PURPOSE
//  Input-side counterpart of the output/display path: collects plaintext and cipher key one byte
//  at a time from a byte source (switch/UART front end), assembles the 128-bit state and the
//  128/192/256-bit key, and presents them with Nk/Nr to the Encrypt/Decrypt cores.
//  Held result is released by an acknowledge handshake; this replaces the hard-coded test vectors.
// PARAMETERS
//  BYTE_W      8   width of one input byte
//  STATE_BYTES 16  bytes in one AES state block
//  KEY_W       256 width of key_out, sized for the largest key
// PORTS
//  clk        in  1    system clock, all state updates on posedge
//  rst        in  1    asynchronous, active-high reset
//  start      in  1    begin a new load; sampled in IDLE only
//  key_size   in  2    00=128, 01=192, 10=256, 11=illegal; latched on accepted start
//  byte_in    in  8    data byte, MSB-first order (state bytes, then key bytes)
//  byte_valid in  1    byte_in is valid this cycle
//  byte_ready out 1    loader accepts a byte this cycle (transfer = byte_valid & byte_ready)
//  abort      in  1    synchronous cancel, returns to IDLE
//  busy       out 1    high in LOAD_STATE or LOAD_KEY
//  state_out  out 128  assembled state, first byte in [127:120]
//  key_out    out 256  assembled key, right-aligned: 192-bit key in [191:0], upper bits zero
//  nk_out     out 4    4/6/8 per latched key_size
//  nr_out     out 4    10/12/14 per latched key_size
//  out_valid  out 1    level, high in HOLD: state_out/key_out/nk/nr stable and complete
//  out_ack    in  1    consumer takes the block; sampled in HOLD only
//  load_done  out 1    one-cycle pulse on HOLD entry
//  err        out 1    one-cycle pulse on start with key_size=11
// BEHAVIOUR
//  Reset: FSM=IDLE, byte counter=0, state_out=0, key_out=0, nk_out=4, nr_out=10, all flags 0.
//  FSM IDLE: start & key_size!=11 -> clear state/key regs, counter=0, latch size -> LOAD_STATE.
//    start & key_size==11 -> err=1 next cycle, stay IDLE, registers untouched.
//  LOAD_STATE: byte_ready=1; per transfer state<={state[119:0],byte_in}, cnt++;
//    transfer with cnt==15 -> cnt=0 -> LOAD_KEY.
//  LOAD_KEY: byte_ready=1; per transfer key<={key[247:0],byte_in}, cnt++;
//    transfer with cnt==4*Nk-1 (15/23/31) -> HOLD; out_valid and load_done high the next cycle.
//  HOLD: byte_ready=0, outputs frozen; out_ack -> IDLE, out_valid low next cycle.
//  Minimum latency: start to out_valid = 1 + 16 + 4*Nk cycles (33/41/49) with byte_valid held 1.
//  byte_valid low: no change, counter holds; gaps of any length are legal.
//  abort (priority over byte transfer and out_ack) in any state -> IDLE next cycle; data regs keep
//    partial contents but out_valid=0; start in the same cycle as abort is ignored.
//  start outside IDLE ignored; out_ack outside HOLD ignored; byte_valid in IDLE/HOLD dropped.
//  Async rst mid-load: immediate return to reset values; no partial load_done or out_valid.
//  Counter 5 bits, never wraps: compared against terminal count, reset to 0 on phase change.
// STRUCTURE
//  Shared package aes_pkg: NK_128/192/256, NR_128/192/256 localparams, key_size encodings,
//    FSM state enum {IDLE, LOAD_STATE, LOAD_KEY, HOLD}; Encrypt/Decrypt tops reuse Nk/Nr constants.
//  One natural sub-module: aes_byte_shifter (parameterised width shift register with enable and
//    synchronous clear), instanced once for state (128) and once for key (256).
// TESTING
//  1 128-bit: key_size=00, bytes 00,11,..,ff then 00,01,..,0f -> out_valid after 33 cycles,
//    state_out=00112233445566778899aabbccddeeff, key_out[127:0]=000102..0f, upper 0, nk=4, nr=10.
//  2 192/256: key bytes 00..17 / 00..1f -> key_out=...0f1011121314151617 (nk=6,nr=12) /
//    000102..1e1f (nk=8,nr=14); out_valid at 41 / 49 cycles; load_done single pulse.
//  3 Backpressure: byte_valid toggled 1-0-1-0 and random gaps -> identical outputs to test 1,
//    only transfers counted; byte_ready=0 in HOLD, extra bytes dropped until out_ack.
//  4 Illegal size: start with key_size=11 -> err pulse 1 cycle, busy stays 0, out_valid 0.
//  5 Abort/reset: abort after 20 bytes -> IDLE, out_valid 0; assert rst after 10 bytes -> all
//    outputs at reset values; subsequent clean 128-bit load still yields test-1 result.
//  6 Handshake: out_ack held low 50 cycles -> outputs stable; out_ack=1 -> out_valid 0 next cycle,
//    new start accepted immediately after.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: Nk/Nr per key length, key_size encodings and the
// input loader FSM states. Encrypt/Decrypt cores import the same Nk/Nr values.
package aes_pkg;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [1:0] KS_128     = 2'b00;
  localparam logic [1:0] KS_192     = 2'b01;
  localparam logic [1:0] KS_256     = 2'b10;
  localparam logic [1:0] KS_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STATE = 2'd1,
    LOAD_KEY   = 2'd2,
    HOLD       = 2'd3
  } load_state_e;

  // Number of 32-bit key words for a key_size code (illegal code falls back to 128).
  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    case (ks)
      KS_192:  return NK_192;
      KS_256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  // Number of rounds for a key_size code.
  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      KS_192:  return NR_192;
      KS_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

  // Index of the last key byte, 4*Nk-1, in the loader's 5-bit counter domain.
  function automatic logic [4:0] key_last_idx(input logic [1:0] ks);
    case (ks)
      KS_192:  return 5'd23;
      KS_256:  return 5'd31;
      default: return 5'd15;
    endcase
  endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// Byte-wide shift register: each enabled cycle shifts the contents up by one
// byte and inserts the new byte at the bottom, so the first byte loaded ends
// up most significant. Synchronous clear starts a fresh block.
module aes_byte_shifter #(
  parameter int W      = 128,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [W-1:0]      data_o
);

  logic [W-1:0] data_q;

  // Shift register with async reset; clear wins over a same-cycle shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= {data_q[W-BYTE_W-1:0], byte_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/aes_input_loader.sv
// AES input loader: collects 16 plaintext bytes and then 16/24/32 key bytes
// from a byte stream, holds the assembled block with Nk/Nr until the consumer
// acknowledges it. Key is right-aligned in key_out because the key shifter is
// cleared at start and only 4*Nk bytes are shifted in.
module aes_input_loader
  import aes_pkg::*;
#(
  parameter int BYTE_W      = 8,
  parameter int STATE_BYTES = 16,
  parameter int KEY_W       = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    key_size,
  input  logic [BYTE_W-1:0]             byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  input  logic                          abort,
  output logic                          busy,
  output logic [BYTE_W*STATE_BYTES-1:0] state_out,
  output logic [KEY_W-1:0]              key_out,
  output logic [3:0]                    nk_out,
  output logic [3:0]                    nr_out,
  output logic                          out_valid,
  input  logic                          out_ack,
  output logic                          load_done,
  output logic                          err
);

  localparam int          STATE_W  = BYTE_W * STATE_BYTES;
  localparam logic [4:0]  ST_LAST  = 5'(STATE_BYTES - 1);

  load_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  ksize_q, ksize_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        xfer;
  logic        start_ok;
  logic        state_last;
  logic        key_last;
  logic        clr;
  logic        st_en;
  logic        key_en;

  // A transfer needs both sides; abort cancels anything else happening this cycle.
  assign xfer       = byte_valid & byte_ready & ~abort;
  assign start_ok   = (state_q == IDLE) & start & ~abort & (key_size != KS_ILLEGAL);
  assign state_last = (cnt_q == ST_LAST);
  assign key_last   = (cnt_q == key_last_idx(ksize_q));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (start_ok)             state_d = LOAD_STATE;
        LOAD_STATE: if (xfer && state_last)   state_d = LOAD_KEY;
        LOAD_KEY:   if (xfer && key_last)     state_d = HOLD;
        HOLD:       if (out_ack)              state_d = IDLE;
        default:                              state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake levels and shifter controls decoded from the current state.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    clr        = 1'b0;
    st_en      = 1'b0;
    key_en     = 1'b0;
    case (state_q)
      IDLE: begin
        clr = start_ok;
      end
      LOAD_STATE: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        st_en      = xfer;
      end
      LOAD_KEY: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        key_en     = xfer;
      end
      HOLD: begin
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte counter, latched key size and one-cycle pulse flags.
  always_comb begin
    cnt_d   = cnt_q;
    ksize_d = ksize_q;
    err_d   = (state_q == IDLE) & start & ~abort & (key_size == KS_ILLEGAL);
    done_d  = (state_q == LOAD_KEY) & xfer & key_last;
    if (abort) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            cnt_d   = '0;
            ksize_d = key_size;
          end
        end
        LOAD_STATE: if (xfer) cnt_d = state_last ? 5'd0 : cnt_q + 5'd1;
        LOAD_KEY:   if (xfer) cnt_d = key_last   ? 5'd0 : cnt_q + 5'd1;
        default: ;
      endcase
    end
  end

  // Registers for counter, key size and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ksize_q <= KS_128;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ksize_q <= ksize_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  aes_byte_shifter #(
    .W      (STATE_W),
    .BYTE_W (BYTE_W)
  ) u_state_shift (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .en_i   (st_en),
    .byte_i (byte_in),
    .data_o (state_out)
  );

  aes_byte_shifter #(
    .W      (KEY_W),
    .BYTE_W (BYTE_W)
  ) u_key_shift (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .en_i   (key_en),
    .byte_i (byte_in),
    .data_o (key_out)
  );

  assign nk_out    = nk_of(ksize_q);
  assign nr_out    = nr_of(ksize_q);
  assign load_done = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Bench for aes_input_loader: table of full loads (three key sizes, with and
// without byte gaps) checked through a scoreboard, plus hand-written sequences
// for illegal size, abort, async reset and the output handshake.
module tb_aes_input_loader;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_size;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         abort;
  logic         busy;
  logic [127:0] state_out;
  logic [255:0] key_out;
  logic [3:0]   nk_out;
  logic [3:0]   nr_out;
  logic         out_valid;
  logic         out_ack;
  logic         load_done;
  logic         err;

  aes_input_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_size   (key_size),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .abort      (abort),
    .busy       (busy),
    .state_out  (state_out),
    .key_out    (key_out),
    .nk_out     (nk_out),
    .nr_out     (nr_out),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .load_done  (load_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] ST_EXP  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128    = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192    = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    logic [1:0]   ks;
    int           mode;    // 0 = byte_valid held, 1 = toggled, 2 = random gaps
    int           nbytes;  // key bytes to send
    logic [127:0] st;
    logic [255:0] key;
    logic [3:0]   nk;
    logic [3:0]   nr;
    int           lat;     // expected start-to-out_valid cycles, 0 = not checked
  } vec_t;

  typedef struct {
    logic [127:0] st;
    logic [255:0] key;
    logic [3:0]   nk;
    logic [3:0]   nr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source byte stream: state bytes 00,11,..,ff then key bytes 00,01,..
  function automatic logic [7:0] src_byte(input int idx);
    if (idx < 16) return 8'(idx * 17);
    return 8'(idx - 16);
  endfunction

  // Offer bytes until n transfers happen or the cycle budget runs out.
  task automatic feed(input int n, input int mode, output int cyc, output int done);
    int guard;
    logic v;
    logic r;
    guard = 0;
    done  = 0;
    cyc   = 0;
    while (done < n && guard < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_in    = src_byte(done);
      r          = byte_ready;
      tick();
      cyc++;
      guard++;
      if (v && r) done++;
    end
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic do_load(input vec_t v, input string tag);
    int   cyc;
    int   done;
    exp_t e;
    e.st  = v.st;
    e.key = v.key;
    e.nk  = v.nk;
    e.nr  = v.nr;
    sb.push_back(e);
    key_size = v.ks;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy"}, 256'(busy), 256'd1);
    feed(16 + v.nbytes, v.mode, cyc, done);
    chk({tag, " transfers"}, 256'(done), 256'(16 + v.nbytes));
    chk({tag, " out_valid"}, 256'(out_valid), 256'd1);
    chk({tag, " load_done"}, 256'(load_done), 256'd1);
    chk({tag, " busy_hold"}, 256'(busy), 256'd0);
    if (v.lat > 0) chk({tag, " latency"}, 256'(1 + cyc), 256'(v.lat));
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard: got output expected none queued", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, " state_out"}, 256'(state_out), 256'(e.st));
        chk({tag, " key_out"}, key_out, e.key);
        chk({tag, " nk_out"}, 256'(nk_out), 256'(e.nk));
        chk({tag, " nr_out"}, 256'(nr_out), 256'(e.nr));
      end
    end
    tick();
    chk({tag, " load_done_pulse"}, 256'(load_done), 256'd0);
    chk({tag, " out_valid_level"}, 256'(out_valid), 256'd1);
  endtask

  // In HOLD: junk bytes are refused and outputs stay frozen.
  task automatic hold_check(input vec_t v, input int n, input string tag);
    int rdy_seen;
    rdy_seen = 0;
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'hee;
      if (byte_ready) rdy_seen++;
      tick();
    end
    byte_valid = 1'b0;
    chk({tag, " byte_ready_in_hold"}, 256'(rdy_seen), 256'd0);
    chk({tag, " hold_valid"}, 256'(out_valid), 256'd1);
    chk({tag, " hold_state"}, 256'(state_out), 256'(v.st));
    chk({tag, " hold_key"}, key_out, v.key);
  endtask

  task automatic release_blk(input string tag);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk({tag, " ack_valid"}, 256'(out_valid), 256'd0);
    chk({tag, " ack_busy"}, 256'(busy), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    int   cyc;
    int   done;

    vecs[0] = '{KS_128, 0, 16, ST_EXP, K128, 4'd4, 4'd10, 33};
    vecs[1] = '{KS_192, 0, 24, ST_EXP, K192, 4'd6, 4'd12, 41};
    vecs[2] = '{KS_256, 0, 32, ST_EXP, K256, 4'd8, 4'd14, 49};
    vecs[3] = '{KS_128, 1, 16, ST_EXP, K128, 4'd4, 4'd10, 0};
    vecs[4] = '{KS_128, 2, 16, ST_EXP, K128, 4'd4, 4'd10, 0};

    rst        = 1'b1;
    start      = 1'b0;
    key_size   = 2'b00;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    abort      = 1'b0;
    out_ack    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("reset state_out", 256'(state_out), 256'd0);
    chk("reset key_out", key_out, 256'd0);
    chk("reset nk", 256'(nk_out), 256'd4);
    chk("reset nr", 256'(nr_out), 256'd10);
    chk("reset flags", 256'({busy, out_valid, byte_ready, load_done, err}), 256'd0);

    // Table of full loads; the first holds 50 cycles before ack, the next
    // start follows the ack immediately.
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_load(vecs[i], tag);
      hold_check(vecs[i], (i == 0) ? 50 : 4, tag);
      release_blk(tag);
    end

    // Illegal key size: single err pulse, nothing else moves.
    key_size = KS_ILLEGAL;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal err", 256'(err), 256'd1);
    chk("illegal busy", 256'(busy), 256'd0);
    chk("illegal valid", 256'(out_valid), 256'd0);
    tick();
    chk("illegal err_pulse", 256'(err), 256'd0);
    chk("illegal busy2", 256'(busy), 256'd0);

    // Abort after 20 bytes of a 256-bit load: partial contents kept, no valid.
    key_size = KS_256;
    start    = 1'b1;
    tick();
    start = 1'b0;
    feed(20, 0, cyc, done);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", 256'(busy), 256'd0);
    chk("abort valid", 256'(out_valid), 256'd0);
    chk("abort ready", 256'(byte_ready), 256'd0);
    chk("abort state_kept", 256'(state_out), 256'(ST_EXP));
    chk("abort key_partial", key_out, 256'h00010203);
    tick();
    chk("abort no_done", 256'(load_done), 256'd0);

    // Start together with abort is ignored.
    key_size = KS_128;
    start    = 1'b1;
    abort    = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start busy", 256'(busy), 256'd0);

    // Abort wins over out_ack in HOLD.
    do_load(vecs[0], "pre_abort_hold");
    out_ack = 1'b1;
    abort   = 1'b1;
    tick();
    out_ack = 1'b0;
    abort   = 1'b0;
    chk("abort_hold valid", 256'(out_valid), 256'd0);

    // Async reset after 10 bytes of a 256-bit load.
    key_size = KS_256;
    start    = 1'b1;
    tick();
    start = 1'b0;
    feed(10, 0, cyc, done);
    #2;
    rst = 1'b1;
    #1;
    chk("rst state_out", 256'(state_out), 256'd0);
    chk("rst key_out", key_out, 256'd0);
    chk("rst nk", 256'(nk_out), 256'd4);
    chk("rst nr", 256'(nr_out), 256'd10);
    chk("rst flags", 256'({busy, out_valid, byte_ready, load_done, err}), 256'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst no_done", 256'({load_done, out_valid}), 256'd0);

    // Clean 128-bit load after reset.
    do_load(vecs[0], "post_rst");
    release_blk("post_rst");

    chk("scoreboard empty", 256'(sb.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
